// File: rtl/conv5x5_mac_unit.sv
// conv5x5_mac_unit
// Seven-stage pipelined 5x5 convolution MAC: 25 signed products, a balanced
// adder tree, bias add, round-half-up, optional ReLU and saturation to WIDTH
// bits. One bundle per clock, no back-pressure, fixed latency of 7 clocks.
module conv5x5_mac_unit #(
   parameter int WIDTH   = 16,
   parameter int FRAC    = 8,
   parameter int TAPS    = 25,
   parameter int RELU_EN = 1,
   parameter int LATENCY = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_i,
   input  logic [WIDTH*(2*TAPS+1)-1:0] data_i,
   input  logic                        clr_sat_i,
   output logic                        valid_o,
   output logic [WIDTH-1:0]            data_o,
   output logic                        sat_o,
   output logic                        sat_sticky_o,
   output logic                        busy_o
);

   localparam int PROD_W = 2*WIDTH;
   localparam int ACC_W  = 2*WIDTH + 5;
   localparam int IN_W   = WIDTH*(2*TAPS+1);

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC-1);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (WIDTH-1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = -(ACC_W'(1) << (WIDTH-1));

   // The adder tree and the stage count below are hand-built for 25 taps.
   if (TAPS != 25 || LATENCY != 7) begin : g_bad_cfg
      $error("conv5x5_mac_unit: tree is built for TAPS=25 and LATENCY=7");
   end

   function automatic logic signed [ACC_W-1:0] sx(input logic signed [PROD_W-1:0] p);
      return ACC_W'(p);
   endfunction

   // Input bundle split: tap 0 sits in the most significant word of each vector.
   logic signed [WIDTH-1:0] w_kern [TAPS];
   logic signed [WIDTH-1:0] w_pix  [TAPS];
   logic signed [WIDTH-1:0] w_bias;

   for (genvar gi = 0; gi < TAPS; gi++) begin : g_unpack
      assign w_kern[gi] = data_i[IN_W-1-gi*WIDTH -: WIDTH];
      assign w_pix[gi]  = data_i[WIDTH*(TAPS+1)-1-gi*WIDTH -: WIDTH];
   end
   assign w_bias = data_i[WIDTH-1:0];

   // Stage valid bits: r_vld[k] qualifies stage k; stage 7 is the output register.
   logic [7:1] r_vld;

   logic signed [PROD_W-1:0] r_prod [TAPS];
   logic signed [ACC_W-1:0]  r_s2   [13];
   logic signed [ACC_W-1:0]  r_s3   [7];
   logic signed [ACC_W-1:0]  r_s4   [4];
   logic signed [ACC_W-1:0]  r_s5   [2];
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [WIDTH-1:0]  r_bias [5];

   logic [WIDTH-1:0] r_data;
   logic             r_sat;
   logic             r_sticky;

   // Datapath S1..S6: multiply, reduce 25->13->7->4->2->1, then add the aligned bias.
   // NOTE: datapath registers carry no reset; their contents only matter while the matching valid bit is set.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so each stage consumes the previous stage's value from the last clock.
      for (int i = 0; i < TAPS; i++) begin
         r_prod[i] <= PROD_W'(w_kern[i]) * PROD_W'(w_pix[i]);
      end
      r_bias[0] <= w_bias;

      for (int j = 0; j < 12; j++) begin
         r_s2[j] <= sx(r_prod[2*j]) + sx(r_prod[2*j+1]);
      end
      r_s2[12]  <= sx(r_prod[24]);
      r_bias[1] <= r_bias[0];

      for (int j = 0; j < 6; j++) begin
         r_s3[j] <= r_s2[2*j] + r_s2[2*j+1];
      end
      r_s3[6]   <= r_s2[12];
      r_bias[2] <= r_bias[1];

      for (int j = 0; j < 3; j++) begin
         r_s4[j] <= r_s3[2*j] + r_s3[2*j+1];
      end
      r_s4[3]   <= r_s3[6];
      r_bias[3] <= r_bias[2];

      for (int j = 0; j < 2; j++) begin
         r_s5[j] <= r_s4[2*j] + r_s4[2*j+1];
      end
      r_bias[4] <= r_bias[3];

      r_acc <= r_s5[0] + r_s5[1] + (ACC_W'(r_bias[4]) <<< FRAC);
   end

   // S7 combinational part: round half up, drop fraction, ReLU, clamp to WIDTH.
   logic signed [ACC_W-1:0] w_biased;
   logic signed [ACC_W-1:0] w_rnd;
   logic [WIDTH-1:0]        w_res;
   logic                    w_clip;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_biased = r_acc + RND_HALF;
      w_rnd    = w_biased >>> FRAC;
      w_res    = w_rnd[WIDTH-1:0];
      w_clip   = 1'b0;
      if (RELU_EN != 0 && w_rnd < 0) begin
         w_res = '0;
      end else if (w_rnd > SAT_MAX) begin
         w_res  = SAT_MAX[WIDTH-1:0];
         w_clip = 1'b1;
      end else if (w_rnd < SAT_MIN) begin
         w_res  = SAT_MIN[WIDTH-1:0];
         w_clip = 1'b1;
      end
   end

   // Valid delay line; reset discards every bundle in flight and ignores valid_i.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld <= {r_vld[6:1], valid_i};
      end
   end

   // Output register and sticky flag; data_o and sat_o hold between results, a new clip beats clr_sat_i.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data   <= '0;
         r_sat    <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         if (r_vld[6]) begin
            r_data <= w_res;
            r_sat  <= w_clip;
         end
         if (r_vld[6] && w_clip) begin
            r_sticky <= 1'b1;
         end else if (clr_sat_i) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign valid_o      = r_vld[7];
   assign data_o       = r_data;
   assign sat_o        = r_sat;
   assign sat_sticky_o = r_sticky;
   assign busy_o       = |r_vld;

endmodule

// File: tb/tb_conv5x5_mac_unit.sv
// tb_conv5x5_mac_unit
// Drives two instances (ReLU on and off) from the same stimulus. Expected
// results come from directed constants and from an arithmetic model of the
// convolution; a monitor compares every result in order with its latency.
module tb_conv5x5_mac_unit;

   localparam int W    = 16;
   localparam int TAPS = 25;
   localparam int DW   = W*(2*TAPS+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          clr_sat_i;

   logic          valid_o, sat_o, sat_sticky_o, busy_o;
   logic [W-1:0]  data_o;
   logic          nr_valid_o, nr_sat_o, nr_sat_sticky_o, nr_busy_o;
   logic [W-1:0]  nr_data_o;

   conv5x5_mac_unit #(.RELU_EN(1)) u_dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .clr_sat_i(clr_sat_i),
      .valid_o(valid_o), .data_o(data_o), .sat_o(sat_o),
      .sat_sticky_o(sat_sticky_o), .busy_o(busy_o)
   );

   conv5x5_mac_unit #(.RELU_EN(0)) u_dut_nr (
      .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .clr_sat_i(clr_sat_i),
      .valid_o(nr_valid_o), .data_o(nr_data_o), .sat_o(nr_sat_o),
      .sat_sticky_o(nr_sat_sticky_o), .busy_o(nr_busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          tag;
      logic [15:0] d;
      logic        s;
      logic [15:0] dn;
      logic        sn;
      int          due;
   } exp_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [15:0]   ed;
      logic          es;
      logic [15:0]   edn;
      logic          esn;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   vec_t tbl[12];

   int n_chk  = 0;
   int n_pass = 0;
   int n_in   = 0;
   int n_out  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pack_fill(input logic [15:0] wf, input logic [15:0] pf,
                                                 input logic [15:0] w0, input logic [15:0] p0,
                                                 input logic [15:0] b);
      logic [DW-1:0] d = '0;
      for (int i = 0; i < TAPS; i++) begin
         d[DW-1-16*i -: 16]          = (i == 0) ? w0 : wf;
         d[16*(TAPS+1)-1-16*i -: 16] = (i == 0) ? p0 : pf;
      end
      d[15:0] = b;
      return d;
   endfunction

   // Reference: exact integer dot product plus bias, round half up, ReLU, clamp.
   function automatic void model(input logic [DW-1:0] d, input bit relu,
                                 output logic [15:0] res, output logic sat);
      longint acc = 0;
      longint rnd;
      logic signed [15:0] k, p, b;
      for (int i = 0; i < TAPS; i++) begin
         k = d[DW-1-16*i -: 16];
         p = d[16*(TAPS+1)-1-16*i -: 16];
         acc += longint'(k) * longint'(p);
      end
      b = d[15:0];
      acc += longint'(b) * 256;
      rnd = (acc + 128) >>> 8;
      sat = 1'b0;
      if (relu && rnd < 0) rnd = 0;
      if (rnd > 32767) begin
         rnd = 32767;
         sat = 1'b1;
      end else if (rnd < -32768) begin
         rnd = -32768;
         sat = 1'b1;
      end
      res = rnd[15:0];
   endfunction

   function automatic logic [DW-1:0] rand_bundle();
      logic [DW-1:0]     d;
      logic signed [8:0]  s9;
      logic signed [11:0] s12;
      int mode = $urandom_range(0, 2);
      for (int j = 0; j < 2*TAPS+1; j++) begin
         s9  = 9'($urandom);
         s12 = 12'($urandom);
         case (mode)
            0:       d[DW-1-16*j -: 16] = 16'(s9);
            1:       d[DW-1-16*j -: 16] = 16'($urandom);
            default: d[DW-1-16*j -: 16] = 16'(s12);
         endcase
      end
      return d;
   endfunction

   task automatic push_const(input int idx);
      exp_t e;
      e.tag = idx; e.d = tbl[idx].ed; e.s = tbl[idx].es;
      e.dn = tbl[idx].edn; e.sn = tbl[idx].esn; e.due = cyc + 7;
      exp_q.push_back(e);
      n_in++;
   endtask

   task automatic push_model(input logic [DW-1:0] d, input int tag);
      exp_t e;
      e.tag = tag;
      model(d, 1'b1, e.d, e.s);
      model(d, 1'b0, e.dn, e.sn);
      e.due = cyc + 7;
      exp_q.push_back(e);
      n_in++;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      check("drain_outstanding", 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   // Output monitor: every valid_o must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("outputs_known", {31'b0, $isunknown({valid_o, sat_o, nr_valid_o, nr_sat_o})}, 0);
         if (valid_o === 1'b1 || nr_valid_o === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("spurious_valid_o", {30'b0, valid_o, nr_valid_o}, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check($sformatf("valid_o[%0d]", mon_e.tag),    {30'b0, valid_o, nr_valid_o}, 32'h3);
               check($sformatf("latency[%0d]", mon_e.tag),    32'(cyc), 32'(mon_e.due));
               check($sformatf("data_o[%0d]", mon_e.tag),     32'(data_o), 32'(mon_e.d));
               check($sformatf("sat_o[%0d]", mon_e.tag),      {31'b0, sat_o}, {31'b0, mon_e.s});
               check($sformatf("nr_data_o[%0d]", mon_e.tag),  32'(nr_data_o), 32'(mon_e.dn));
               check($sformatf("nr_sat_o[%0d]", mon_e.tag),   {31'b0, nr_sat_o}, {31'b0, mon_e.sn});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int in0, out0, n;
      logic [DW-1:0] d;

      tbl[0]  = '{pack_fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000), 16'h1900, 1'b0, 16'h1900, 1'b0};
      tbl[1]  = '{pack_fill(16'h0000, 16'h0000, 16'h0001, 16'h0080, 16'h0000), 16'h0001, 1'b0, 16'h0001, 1'b0};
      tbl[2]  = '{pack_fill(16'h0000, 16'h0000, 16'h0001, 16'h007F, 16'h0000), 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[3]  = '{pack_fill(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00), 16'h0000, 1'b0, 16'hFF00, 1'b0};
      tbl[4]  = '{pack_fill(16'h0000, 16'h0000, 16'hFFFF, 16'h0080, 16'h0000), 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{pack_fill(16'h0000, 16'h0000, 16'hFFFF, 16'h0081, 16'h0000), 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      tbl[6]  = '{pack_fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000), 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
      tbl[7]  = '{pack_fill(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000), 16'h0000, 1'b0, 16'h8000, 1'b1};
      tbl[8]  = '{pack_fill(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF), 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
      tbl[9]  = '{pack_fill(16'h0000, 16'h0000, 16'h7FFF, 16'h0100, 16'h0000), 16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
      tbl[10] = '{pack_fill(16'h0000, 16'h0000, 16'h8000, 16'h0100, 16'h0000), 16'h0000, 1'b0, 16'h8000, 1'b0};
      tbl[11] = '{pack_fill(16'h0000, 16'h0000, 16'h7FFF, 16'h0101, 16'h0000), 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};

      // Reset state.
      rst = 1'b1; valid_i = 1'b0; data_i = '0; clr_sat_i = 1'b0;
      repeat (3) tick();
      check("rst_valid_o", {31'b0, valid_o}, 0);
      check("rst_data_o",  32'(data_o), 0);
      check("rst_sat_o",   {31'b0, sat_o}, 0);
      check("rst_sticky",  {31'b0, sat_sticky_o}, 0);
      check("rst_busy",    {31'b0, busy_o}, 0);
      rst = 1'b0;

      // Directed vectors back to back.
      for (int i = 0; i < 12; i++) begin
         tick();
         valid_i = 1'b1; data_i = tbl[i].d;
         push_const(i);
      end
      tick();
      valid_i = 1'b0;
      wait_drain();
      check("sticky_after_table",    {31'b0, sat_sticky_o}, 1);
      check("nr_sticky_after_table", {31'b0, nr_sat_sticky_o}, 1);

      // clr_sat_i alone clears the sticky flag.
      clr_sat_i = 1'b1;
      tick();
      clr_sat_i = 1'b0;
      check("sticky_cleared",    {31'b0, sat_sticky_o}, 0);
      check("nr_sticky_cleared", {31'b0, nr_sat_sticky_o}, 0);

      // clr_sat_i coinciding with a clipping result: set wins.
      tick();
      valid_i = 1'b1; data_i = tbl[6].d;
      push_const(6);
      tick();
      valid_i = 1'b0;
      repeat (5) tick();
      clr_sat_i = 1'b1;
      tick();
      clr_sat_i = 1'b0;
      check("sticky_set_wins",    {31'b0, sat_sticky_o}, 1);
      check("nr_sticky_set_wins", {31'b0, nr_sat_sticky_o}, 1);
      wait_drain();

      // Random stream with gaps.
      in0 = n_in; out0 = n_out;
      n = 0;
      while (n < 40) begin
         tick();
         if ($urandom_range(0, 3) != 0) begin
            d = rand_bundle();
            valid_i = 1'b1; data_i = d;
            push_model(d, 100 + n);
            n++;
         end else begin
            valid_i = 1'b0; data_i = rand_bundle();
         end
      end
      tick();
      valid_i = 1'b0;
      n = 0;
      while (busy_o === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("busy_fall_clocks", 32'(n), 7);
      wait_drain();
      check("pulse_count", 32'(n_out - out0), 32'(n_in - in0));

      // Reset with bundles in flight.
      for (int i = 0; i < 4; i++) begin
         tick();
         valid_i = 1'b1; data_i = rand_bundle();
      end
      tick();
      rst = 1'b1; valid_i = 1'b1; data_i = tbl[0].d;
      exp_q.delete();
      tick();
      check("midrst_busy",    {31'b0, busy_o}, 0);
      check("midrst_nr_busy", {31'b0, nr_busy_o}, 0);
      check("midrst_valid_o", {31'b0, valid_o}, 0);
      check("midrst_data_o",  32'(data_o), 0);
      rst = 1'b0; valid_i = 1'b0;
      out0 = n_out;
      repeat (12) tick();
      check("no_valid_after_reset", 32'(n_out - out0), 0);
      tick();
      valid_i = 1'b1; data_i = tbl[0].d;
      push_const(0);
      tick();
      valid_i = 1'b0;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
